// File: rtl/rr_arb_mux_pkg.sv
// Shared types and helpers for the round-robin arbitrating multiplexer.
package rr_arb_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } arb_mode_e;

    // Pointer value following grant g, wrapping at num_ch so it never reaches num_ch.
    function automatic int next_ptr(input int g, input int num_ch);
        return (g == num_ch - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant selection (fixed priority or round-robin) plus the round-robin pointer.
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              mode_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   gnt_idx_o,
    output logic              gnt_vld_o
);

    // One spare bit so ptr + offset cannot overflow before the wrap subtraction.
    localparam logic [CH_W:0] NUM_CH_X = (CH_W + 1)'(NUM_CH);

    arb_mode_e       mode;
    logic [CH_W-1:0] ptr_q;
    logic [CH_W-1:0] ptr_d;
    logic [CH_W:0]   cand;

    assign mode = arb_mode_e'(mode_i);

    // Walk the search order (from ch0 or from ptr with wrap); the first requester wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mode == MODE_RR) begin
                cand = {1'b0, ptr_q} + (CH_W + 1)'(i);
            end else begin
                cand = (CH_W + 1)'(i);
            end
            if (cand >= NUM_CH_X) begin
                cand = cand - NUM_CH_X;
            end
            if (en_i && !gnt_vld_o && req_i[cand[CH_W-1:0]]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = cand[CH_W-1:0];
            end
        end
        if (gnt_vld_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

    // Move the pointer just past the winner, only on a round-robin grant.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld_o && (mode == MODE_RR)) begin
            ptr_d = CH_W'(next_ptr(int'(gnt_idx_o), NUM_CH));
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N:1 arbitrating multiplexer: per-channel valid/ready in, one registered word out.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic              load_en;
    logic              arb_en;
    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_vld;
    logic [WIDTH-1:0]  sel_data;

    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic              out_valid_q, out_valid_d;

    // The register can take a new word when empty or when its word leaves this cycle.
    // Reset blocks arbitration so no channel sees ready during the reset cycle.
    assign load_en = !out_valid_q || out_ready;
    assign arb_en  = load_en && !reset;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .en_i      (arb_en),
        .req_i     (in_valid),
        .mode_i    (mode),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign in_ready = gnt;

    // Data mux driven directly by the one-hot grant.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt[k]) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage: reload on grant, empty when nothing requests, hold under backpressure.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (load_en) begin
            out_valid_d = gnt_vld;
            if (gnt_vld) begin
                out_data_d = sel_data;
                out_ch_d   = gnt_idx;
            end
        end
    end

    // Output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule
